// File: rtl/mxu_sequencer_if.sv
// mxu_sequencer_if: command/datapath control bundle around the MXU sequencer.
// Signal prefixes are from the sequencer's point of view (i_ into it, o_ out of it).
// The slave modport belongs to the sequencer; the master modport belongs to whatever
// drives commands and observes the array controls.
// Optional feature macro: MXU_PERF_CNT_EN adds the two performance counters.
// ROWS and LEN_W must match the values given to the sequencer instance.
interface mxu_sequencer_if #(
  parameter int ROWS  = 4,
  parameter int LEN_W = 8
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             i_start;
  logic [LEN_W-1:0] i_n_vectors;
  logic             i_stall;
  logic             i_data_valid_in;

  logic             o_busy;
  logic             o_done;
  logic             o_mxu_ce;
  logic             o_mxu_sclr;
  logic             o_w_load_en;
  logic [ROW_W-1:0] o_w_row_sel;
  logic             o_data_req;
  logic             o_res_valid;
`ifdef MXU_PERF_CNT_EN
  logic [31:0]      o_perf_busy_cyc;
  logic [31:0]      o_perf_stall_cyc;

  modport master (
    output i_start, i_n_vectors, i_stall, i_data_valid_in,
    input  o_busy, o_done, o_mxu_ce, o_mxu_sclr, o_w_load_en, o_w_row_sel,
           o_data_req, o_res_valid, o_perf_busy_cyc, o_perf_stall_cyc
  );

  modport slave (
    input  i_start, i_n_vectors, i_stall, i_data_valid_in,
    output o_busy, o_done, o_mxu_ce, o_mxu_sclr, o_w_load_en, o_w_row_sel,
           o_data_req, o_res_valid, o_perf_busy_cyc, o_perf_stall_cyc
  );
`else
  modport master (
    output i_start, i_n_vectors, i_stall, i_data_valid_in,
    input  o_busy, o_done, o_mxu_ce, o_mxu_sclr, o_w_load_en, o_w_row_sel,
           o_data_req, o_res_valid
  );

  modport slave (
    input  i_start, i_n_vectors, i_stall, i_data_valid_in,
    output o_busy, o_done, o_mxu_ce, o_mxu_sclr, o_w_load_en, o_w_row_sel,
           o_data_req, o_res_valid
  );
`endif
endinterface

// File: rtl/mxu_sequencer.sv
// mxu_sequencer: control FSM for a ROWS x COLS systolic array of mxu_mac cells.
// Per job: clear the array, load weights row by row, stream n_vectors inputs
// under clock-enable gating, drain the pipeline, then pulse done.
// A FILL-deep token pipe (advanced only by mxu_ce) tracks which ce-cycles carry a
// real vector, so res_valid fires exactly once per accepted vector, FILL ce-cycles
// after its accept, regardless of stalls or input gaps.
// Reset is asynchronous and active-low on the port named reset.
// Optional feature macro: MXU_PERF_CNT_EN (busy / stall cycle counters).
module mxu_sequencer #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAC_LAT = 3,
  parameter int LEN_W   = 8
) (
  input  logic            clk,
  input  logic            reset,
  mxu_sequencer_if.slave  io_bus
);

  localparam int FILL  = MAC_LAT * ROWS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Array geometry must be non-degenerate; COLS only documents the array width.
  if (ROWS < 1 || COLS < 1 || MAC_LAT < 1 || LEN_W < 1) begin : g_bad_param
    $error("mxu_sequencer: ROWS, COLS, MAC_LAT and LEN_W must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_remain;
  logic [ROW_W-1:0] r_row;
  logic [FILL-1:0]  r_tok;
  logic             r_sclr;

  logic             w_accept;
  logic             w_ce;
  logic             w_req;
  logic             w_wload;
  logic             w_done;
  logic             w_tok_in;
  logic [FILL:0]    w_tok_ext;
  logic [FILL:0]    w_tok_zero_shift;
  logic             w_start_ok;

  // A start is only honoured while idle; anything else is ignored.
  assign w_start_ok = (r_state == S_IDLE) && io_bus.i_start;

  // Token pipe contents after one ce-cycle with nothing new shifted in (DRAIN view).
  assign w_tok_zero_shift = {r_tok, 1'b0};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and per-state array controls.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left one
    // unassigned would infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ce         = 1'b0;
    w_req        = 1'b0;
    w_wload      = 1'b0;
    w_done       = 1'b0;
    w_tok_in     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (io_bus.i_start) w_state_next = S_CLEAR;
      end

      S_CLEAR: begin
        w_ce         = 1'b1;
        w_state_next = S_LOAD_W;
      end

      S_LOAD_W: begin
        w_wload = 1'b1;
        if (r_row == ROW_W'(ROWS - 1)) begin
          w_state_next = (r_remain == '0) ? S_DONE : S_STREAM;
        end
      end

      S_STREAM: begin
        w_accept = io_bus.i_data_valid_in && !io_bus.i_stall;
        w_ce     = w_accept;
        w_req    = w_accept;
        w_tok_in = w_accept;
        if (w_accept && r_remain == LEN_W'(1)) w_state_next = S_DRAIN;
      end

      S_DRAIN: begin
        w_ce = !io_bus.i_stall;
        // Leave as soon as this cycle's shift empties the pipe; a stalled cycle
        // cannot empty it because the tokens hold still.
        if (r_tok == '0 ||
            (!io_bus.i_stall && w_tok_zero_shift[FILL-1:0] == '0)) begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // Remaining-vector count: loaded on accepted start, one down per accepted vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_remain <= '0;
    else if (w_start_ok) r_remain <= io_bus.i_n_vectors;
    else if (w_accept)   r_remain <= r_remain - LEN_W'(1);
  end

  // Weight row pointer: walks 0..ROWS-1 during LOAD_W and sits at 0 otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
    end else if (w_wload && r_row != ROW_W'(ROWS - 1)) begin
      r_row <= r_row + ROW_W'(1);
    end else begin
      r_row <= '0;
    end
  end

  assign w_tok_ext = {r_tok, w_tok_in};

  // Token pipe: advances in lock-step with the array, only on ce-cycles.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the token pipe is a small flop shift register, not a RAM, so it is
    // reset; a mid-job reset must not leave stale tokens that fire res_valid later.
    if (!reset)    r_tok <= '0;
    else if (w_ce) r_tok <= w_tok_ext[FILL-1:0];
  end

  // Array clear: held through reset, then asserted only for the CLEAR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sclr <= 1'b1;
    else        r_sclr <= (w_state_next == S_CLEAR);
  end

  assign io_bus.o_busy      = (r_state != S_IDLE);
  assign io_bus.o_done      = w_done;
  assign io_bus.o_mxu_ce    = w_ce;
  assign io_bus.o_mxu_sclr  = r_sclr;
  assign io_bus.o_w_load_en = w_wload;
  assign io_bus.o_w_row_sel = r_row;
  assign io_bus.o_data_req  = w_req;
  assign io_bus.o_res_valid = w_ce && r_tok[FILL-1];

`ifdef MXU_PERF_CNT_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;
  logic        w_in_flow;

  assign w_in_flow = (r_state == S_STREAM) || (r_state == S_DRAIN);

  // Busy-cycle counter: cleared by an accepted start, saturating, held when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               r_perf_busy <= '0;
    else if (w_start_ok)                      r_perf_busy <= '0;
    else if (io_bus.o_busy && !(&r_perf_busy)) r_perf_busy <= r_perf_busy + 32'd1;
  end

  // Stall-cycle counter: STREAM/DRAIN cycles where the array was frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  r_perf_stall <= '0;
    else if (w_start_ok)                         r_perf_stall <= '0;
    else if (w_in_flow && !w_ce && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 32'd1;
  end

  assign io_bus.o_perf_busy_cyc  = r_perf_busy;
  assign io_bus.o_perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_mxu_sequencer.sv
// tb_mxu_sequencer: scoreboard bench for mxu_sequencer (ROWS=4, MAC_LAT=3, FILL=12).
// Each test pushes the cycle numbers at which data_req, w_load_en, res_valid and
// done must fire (cycle 0 = the cycle start is high), then run_job drives the
// stimulus and pops one entry per observed pulse.
module tb_mxu_sequencer;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int MAC_LAT = 3;
  localparam int LEN_W   = 8;
  localparam int MAX_CYC = 600;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mxu_sequencer_if #(.ROWS(ROWS), .LEN_W(LEN_W)) bus ();

  mxu_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .MAC_LAT(MAC_LAT), .LEN_W(LEN_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_req[$];
  int exp_res[$];
  int exp_wl[$];
  int exp_done[$];
  int ce_low;
  int done_cyc;

  function automatic logic [6:0] out_vec();
    return {bus.o_busy, bus.o_done, bus.o_mxu_ce, bus.o_mxu_sclr,
            bus.o_w_load_en, bus.o_data_req, bus.o_res_valid};
  endfunction

  // Weight-load cycles and the no-stall stream/result/done timing for n vectors.
  task automatic push_nominal(input int n);
    for (int r = 0; r < ROWS; r++) exp_wl.push_back(2 + r);
    for (int i = 0; i < n; i++) begin
      exp_req.push_back(6 + i);
      exp_res.push_back(6 + i + MAC_LAT * ROWS);
    end
    exp_done.push_back((n > 0) ? 6 + n - 1 + MAC_LAT * ROWS + 1 : 6);
  endtask

  // Drive one job; windows are inclusive cycle ranges (-1 = unused).
  // rst_cyc >= 0 pulls reset low inside that cycle and ends the job there.
  task automatic run_job(input int n, input int st_lo, input int st_hi,
                         input int dv_lo, input int dv_hi,
                         input int pulse_cyc, input int rst_cyc);
    int  k;
    int  e;
    bit  finished;
    bit  busy_bad;
    bit  exp_busy;
    ce_low   = 0;
    done_cyc = -1;
    busy_bad = 1'b0;
    finished = 1'b0;
    k        = 0;
    @(posedge clk);
    #1;
    while (!finished) begin
      bus.i_start         = (k == 0) || (k == pulse_cyc);
      bus.i_n_vectors     = (k == 0) ? LEN_W'(n) : LEN_W'(8'hA5);
      bus.i_stall         = (k >= st_lo) && (k <= st_hi);
      bus.i_data_valid_in = !((k >= dv_lo) && (k <= dv_hi));
      if (k == rst_cyc) begin
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (out_vec() !== 7'b0001000) begin
          n_errors++;
          $display("FAIL mid_job_reset_outputs: got %b expected 0001000", out_vec());
        end
        finished = 1'b1;
      end else begin
        @(negedge clk);
        if (bus.o_res_valid) begin
          n_checks++;
          if (exp_res.size() == 0) begin
            n_errors++;
            $display("FAIL res_valid_extra: pulse at cycle %0d, expected none", k);
          end else begin
            e = exp_res.pop_front();
            if (e !== k) begin
              n_errors++;
              $display("FAIL res_valid_cycle: got cycle %0d expected cycle %0d", k, e);
            end
          end
        end
        if (bus.o_data_req) begin
          n_checks++;
          if (exp_req.size() == 0) begin
            n_errors++;
            $display("FAIL data_req_extra: pulse at cycle %0d, expected none", k);
          end else begin
            e = exp_req.pop_front();
            if (e !== k) begin
              n_errors++;
              $display("FAIL data_req_cycle: got cycle %0d expected cycle %0d", k, e);
            end
          end
        end
        if (bus.o_w_load_en) begin
          n_checks++;
          if (exp_wl.size() == 0) begin
            n_errors++;
            $display("FAIL w_load_extra: pulse at cycle %0d, expected none", k);
          end else begin
            e = exp_wl.pop_front();
            if (e !== k || int'(bus.o_w_row_sel) !== e - 2) begin
              n_errors++;
              $display("FAIL w_load_cycle_row: got cycle %0d row %0d expected cycle %0d row %0d",
                       k, bus.o_w_row_sel, e, e - 2);
            end
          end
        end
        if (k == 1) begin
          n_checks++;
          if (bus.o_mxu_sclr !== 1'b1 || bus.o_mxu_ce !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_cycle: got sclr=%b ce=%b expected sclr=1 ce=1",
                     bus.o_mxu_sclr, bus.o_mxu_ce);
          end
        end
        exp_busy = (k >= 1) && !(done_cyc >= 0 && k > done_cyc);
        if (bus.o_busy !== exp_busy) begin
          busy_bad = 1'b1;
          $display("busy at cycle %0d is %b, expected %b", k, bus.o_busy, exp_busy);
        end
        if (k >= 6 && bus.o_busy && !bus.o_done && !bus.o_mxu_ce) ce_low++;
        if (bus.o_done) begin
          n_checks++;
          if (exp_done.size() == 0) begin
            n_errors++;
            $display("FAIL done_extra: pulse at cycle %0d, expected none", k);
          end else begin
            e = exp_done.pop_front();
            if (e !== k) begin
              n_errors++;
              $display("FAIL done_cycle: got cycle %0d expected cycle %0d", k, e);
            end
          end
          if (done_cyc < 0) done_cyc = k;
        end
        if (done_cyc >= 0 && k == done_cyc + 1) finished = 1'b1;
        if (k >= MAX_CYC) begin
          n_checks++;
          n_errors++;
          $display("FAIL job_timeout: no done after %0d cycles, expected done", k);
          finished = 1'b1;
        end
        if (!finished) begin
          @(posedge clk);
          #1;
        end
        k++;
      end
    end
    bus.i_start         = 1'b0;
    bus.i_stall         = 1'b0;
    bus.i_data_valid_in = 1'b0;
    n_checks++;
    if (busy_bad) begin
      n_errors++;
      $display("FAIL busy_window: got busy outside cycles 1..done, expected busy exactly there");
    end
    n_checks++;
    if (exp_req.size() + exp_res.size() + exp_wl.size() + exp_done.size() != 0) begin
      n_errors++;
      $display("FAIL missing_pulses: got %0d req %0d res %0d wl %0d done outstanding, expected 0",
               exp_req.size(), exp_res.size(), exp_wl.size(), exp_done.size());
    end
    exp_req.delete();
    exp_res.delete();
    exp_wl.delete();
    exp_done.delete();
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (out_vec() !== 7'b0001000 || bus.o_w_row_sel !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b row %0d expected 0001000 row 0",
               out_vec(), bus.o_w_row_sel);
    end
`ifdef MXU_PERF_CNT_EN
    n_checks++;
    if (bus.o_perf_busy_cyc !== 32'd0 || bus.o_perf_stall_cyc !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_perf: got %0d/%0d expected 0/0",
               bus.o_perf_busy_cyc, bus.o_perf_stall_cyc);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_mxu_sclr !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL sclr_release: got sclr=%b busy=%b expected sclr=0 busy=0",
               bus.o_mxu_sclr, bus.o_busy);
    end
  endtask

  task automatic test_basic();
    push_nominal(2);
    run_job(2, -1, -1, -1, -1, -1, -1);
    n_checks++;
    if (ce_low !== 0) begin
      n_errors++;
      $display("FAIL basic_ce_low: got %0d frozen cycles expected 0", ce_low);
    end
  endtask

  task automatic test_stall();
    for (int r = 0; r < ROWS; r++) exp_wl.push_back(2 + r);
    exp_req.push_back(6);
    exp_req.push_back(7);
    exp_res.push_back(21);
    exp_res.push_back(22);
    exp_done.push_back(23);
    run_job(2, 10, 12, -1, -1, -1, -1);
    n_checks++;
    if (ce_low !== 3) begin
      n_errors++;
      $display("FAIL stall_ce_low: got %0d frozen cycles expected 3", ce_low);
    end
`ifdef MXU_PERF_CNT_EN
    n_checks++;
    if (bus.o_perf_busy_cyc !== 32'd23 || bus.o_perf_stall_cyc !== 32'd3) begin
      n_errors++;
      $display("FAIL stall_perf: got busy=%0d stall=%0d expected busy=23 stall=3",
               bus.o_perf_busy_cyc, bus.o_perf_stall_cyc);
    end
`endif
  endtask

  task automatic test_data_gap();
    for (int r = 0; r < ROWS; r++) exp_wl.push_back(2 + r);
    exp_req.push_back(8);
    exp_req.push_back(9);
    exp_res.push_back(20);
    exp_res.push_back(21);
    exp_done.push_back(22);
    run_job(2, -1, -1, 6, 7, -1, -1);
    n_checks++;
    if (ce_low !== 2) begin
      n_errors++;
      $display("FAIL gap_ce_low: got %0d frozen cycles expected 2", ce_low);
    end
  endtask

  task automatic test_zero_vectors();
    push_nominal(0);
    run_job(0, -1, -1, -1, -1, -1, -1);
  endtask

  task automatic test_start_while_busy();
    push_nominal(2);
    run_job(2, -1, -1, -1, -1, 8, -1);
  endtask

  task automatic test_reset_mid_job();
    for (int r = 0; r < ROWS; r++) exp_wl.push_back(2 + r);
    exp_req.push_back(6);
    run_job(2, -1, -1, -1, -1, -1, 7);
    @(negedge clk);
    reset = 1'b1;
    push_nominal(2);
    run_job(2, -1, -1, -1, -1, -1, -1);
  endtask

  task automatic test_back_to_back_max();
    push_nominal(1);
    run_job(1, -1, -1, -1, -1, -1, -1);
    push_nominal(255);
    run_job(255, -1, -1, -1, -1, -1, -1);
  endtask

  initial begin
    reset               = 1'b0;
    bus.i_start         = 1'b0;
    bus.i_n_vectors     = '0;
    bus.i_stall         = 1'b0;
    bus.i_data_valid_in = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_data_gap();
    test_zero_vectors();
    test_start_while_busy();
    test_reset_mid_job();
    test_back_to_back_max();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
